// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   REG_AW / REG_NUM      : register address width and register count
//   WB_SRC_ALU/WB_SRC_LSU : bit positions of each requester in the one-hot grant
//   wb_src_e              : encoding of the round-robin "last granted" pointer
//   reg_onehot()          : decodes a register address to a one-hot mask, x0 -> 0
package regfile_wb_arbiter_pkg;

    localparam int REG_AW     = 5;
    localparam int REG_NUM    = 32;
    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_LSU = 1;

    typedef enum logic [0:0] {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;

    // x0 is hardwired to zero, so it never maps to a scoreboard bit.
    function automatic logic [REG_NUM-1:0] reg_onehot(input logic [REG_AW-1:0] addr);
        logic [REG_NUM-1:0] v;
        v = '0;
        if (addr != {REG_AW{1'b0}}) begin
            v[addr] = 1'b1;
        end else begin
            v = '0;
        end
        return v;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_rr_arb2.sv
// Two-input writeback arbiter (ALU vs LSU).
//   clk, rst     : clock, asynchronous active-low reset
//   alu_valid    : ALU request
//   lsu_valid    : LSU request
//   gnt[1:0]     : one-hot grant, combinational (bit WB_SRC_ALU / WB_SRC_LSU)
// LSU_PRIORITY != 0 gives the LSU fixed priority; otherwise contended cycles
// alternate, starting with the LSU after reset.
module wb_rr_arb2
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int LSU_PRIORITY = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       alu_valid,
    input  logic       lsu_valid,
    output logic [1:0] gnt
);

    wb_src_e    last_src_r;
    logic [1:0] gnt_s;

    // Grant selection: single requester wins outright, contention uses policy.
    always_comb begin
        gnt_s = 2'b00;
        if (alu_valid && lsu_valid) begin
            if ((LSU_PRIORITY != 0) || (last_src_r == SRC_ALU)) begin
                gnt_s[WB_SRC_LSU] = 1'b1;
            end else begin
                gnt_s[WB_SRC_ALU] = 1'b1;
            end
        end else if (alu_valid) begin
            gnt_s[WB_SRC_ALU] = 1'b1;
        end else if (lsu_valid) begin
            gnt_s[WB_SRC_LSU] = 1'b1;
        end else begin
            gnt_s = 2'b00;
        end
    end

    assign gnt = gnt_s;

    // Round-robin pointer: remembers the last granted source, moves only on a grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_src_r <= SRC_ALU;
        end else if (gnt_s != 2'b00) begin
            last_src_r <= gnt_s[WB_SRC_LSU] ? SRC_LSU : SRC_ALU;
        end else begin
            last_src_r <= last_src_r;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register file writeback arbiter with busy scoreboard and stall counters.
//   clk, rst                         : clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data        : ALU writeback request
//   alu_ready                        : ALU grant this cycle (combinational)
//   lsu_valid/lsu_rd/lsu_data        : LSU writeback request
//   lsu_ready                        : LSU grant this cycle (combinational)
//   rf_we/rf_rd_addr/rf_rd_din       : registered register-file write port
//   sb_set/sb_set_addr               : decode reserves a destination register
//   rs1_q/rs2_q, hz_rs1/hz_rs2       : RAW hazard queries (combinational)
//   busy_mask                        : scoreboard bits, bit 0 always 0
//   sb_err                           : sticky scoreboard protocol error
//   alu_stall_cnt/lsu_stall_cnt      : saturating stall-cycle counters
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int LSU_PRIORITY = 0,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [4:0]        alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    output logic              alu_ready,
    input  logic              lsu_valid,
    input  logic [4:0]        lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    output logic              lsu_ready,
    output logic              rf_we,
    output logic [4:0]        rf_rd_addr,
    output logic [XLEN-1:0]   rf_rd_din,
    input  logic              sb_set,
    input  logic [4:0]        sb_set_addr,
    input  logic [4:0]        rs1_q,
    input  logic [4:0]        rs2_q,
    output logic              hz_rs1,
    output logic              hz_rs2,
    output logic [31:0]       busy_mask,
    output logic              sb_err,
    output logic [CNT_W-1:0]  alu_stall_cnt,
    output logic [CNT_W-1:0]  lsu_stall_cnt
);

    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [REG_NUM-1:0] NO_X0    = {{(REG_NUM-1){1'b1}}, 1'b0};

    logic [1:0]          gnt_s;
    logic                any_gnt_s;
    logic [REG_AW-1:0]   sel_rd_s;
    logic [XLEN-1:0]     sel_data_s;

    logic [REG_NUM-1:0]  busy_r;
    logic [REG_NUM-1:0]  set_vec_s;
    logic [REG_NUM-1:0]  clr_vec_s;
    logic [REG_NUM-1:0]  busy_nxt_s;
    logic                err_set_s;
    logic                sb_err_r;

    logic [CNT_W-1:0]    alu_stall_r;
    logic [CNT_W-1:0]    lsu_stall_r;

    wb_rr_arb2 #(
        .LSU_PRIORITY (LSU_PRIORITY)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .lsu_valid (lsu_valid),
        .gnt       (gnt_s)
    );

    assign alu_ready = gnt_s[WB_SRC_ALU];
    assign lsu_ready = gnt_s[WB_SRC_LSU];
    assign any_gnt_s = |gnt_s;

    // Mux the granted requester's destination and data toward the write register.
    always_comb begin
        sel_rd_s   = '0;
        sel_data_s = '0;
        if (gnt_s[WB_SRC_LSU]) begin
            sel_rd_s   = lsu_rd;
            sel_data_s = lsu_data;
        end else begin
            sel_rd_s   = alu_rd;
            sel_data_s = alu_data;
        end
    end

    // Write-port register: loads on a grant, rd = 0 is consumed without a write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we      <= 1'b0;
            rf_rd_addr <= '0;
            rf_rd_din  <= '0;
        end else if (any_gnt_s) begin
            rf_we      <= (sel_rd_s != {REG_AW{1'b0}});
            rf_rd_addr <= sel_rd_s;
            rf_rd_din  <= sel_data_s;
        end else begin
            rf_we      <= 1'b0;
            rf_rd_addr <= rf_rd_addr;
            rf_rd_din  <= rf_rd_din;
        end
    end

    // Scoreboard next state: clear on the register-file write edge, set wins a
    // same-register race; protocol violations flag a sticky error.
    always_comb begin
        set_vec_s = '0;
        clr_vec_s = '0;
        if (sb_set) begin
            set_vec_s = reg_onehot(sb_set_addr);
        end else begin
            set_vec_s = '0;
        end
        if (rf_we) begin
            clr_vec_s = reg_onehot(rf_rd_addr);
        end else begin
            clr_vec_s = '0;
        end
        busy_nxt_s = ((busy_r & ~clr_vec_s) | set_vec_s) & NO_X0;
        // Double reservation (not rescued by a same-edge clear) or write to an idle register.
        err_set_s  = (|(set_vec_s & busy_r & ~clr_vec_s)) | (|(clr_vec_s & ~busy_r));
    end

    // Scoreboard and sticky error state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r   <= '0;
            sb_err_r <= 1'b0;
        end else begin
            busy_r   <= busy_nxt_s;
            sb_err_r <= sb_err_r | err_set_s;
        end
    end

    assign busy_mask = busy_r;
    assign sb_err    = sb_err_r;
    assign hz_rs1    = (rs1_q != 5'd0) ? busy_r[rs1_q] : 1'b0;
    assign hz_rs2    = (rs2_q != 5'd0) ? busy_r[rs2_q] : 1'b0;

    // Saturating stall counters: one count per cycle a request waits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_stall_r <= '0;
            lsu_stall_r <= '0;
        end else begin
            if (alu_valid && !alu_ready && (alu_stall_r != CNT_MAX)) begin
                alu_stall_r <= alu_stall_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                alu_stall_r <= alu_stall_r;
            end
            if (lsu_valid && !lsu_ready && (lsu_stall_r != CNT_MAX)) begin
                lsu_stall_r <= lsu_stall_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                lsu_stall_r <= lsu_stall_r;
            end
        end
    end

    assign alu_stall_cnt = alu_stall_r;
    assign lsu_stall_cnt = lsu_stall_r;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: the ALU and the load/store unit (LSU).
- Arbitrates between them with a valid/ready handshake and drives registered write signals (rf_we / rf_rd_addr / rf_rd_din) into the register file.
- Holds a 31-entry busy scoreboard of destination registers reserved at issue, so decode can detect RAW hazards.
- Keeps saturating stall counters for performance monitoring.

Parameters:
XLEN, 32, data width of writeback values
LSU_PRIORITY, 0, 0 = round-robin arbitration; 1 = fixed priority, LSU wins
CNT_W, 16, width of each stall counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
alu_valid  in  1  ALU writeback request
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
alu_ready  out  1  ALU request accepted this cycle (combinational)
lsu_valid  in  1  LSU writeback request
lsu_rd  in  5  LSU destination register
lsu_data  in  XLEN  load result
lsu_ready  out  1  LSU request accepted this cycle (combinational)
rf_we  out  1  register file write enable (registered)
rf_rd_addr  out  5  register file write address (registered)
rf_rd_din  out  XLEN  register file write data (registered)
sb_set  in  1  decode reserves a destination register
sb_set_addr  in  5  register being reserved
rs1_q  in  5  hazard query address 1
rs2_q  in  5  hazard query address 2
hz_rs1  out  1  busy[rs1_q] (combinational; 0 when rs1_q = 0)
hz_rs2  out  1  busy[rs2_q] (combinational; 0 when rs2_q = 0)
busy_mask  out  32  scoreboard bits; bit 0 always 0
sb_err  out  1  sticky scoreboard protocol error
alu_stall_cnt  out  CNT_W  cycles with alu_valid high and alu_ready low, saturating
lsu_stall_cnt  out  CNT_W  cycles with lsu_valid high and lsu_ready low, saturating

Behaviour:
- Reset (rst = 0, takes effect immediately, asynchronous):
  - rf_we, rf_rd_addr, rf_rd_din = 0.
  - busy_mask = 0, sb_err = 0, both stall counters = 0.
  - Round-robin pointer (last_lsu) = 0, so the LSU wins the first contended cycle.
  - Reset mid-transfer drops any pending write; no partial commit.
- Arbitration (one grant per cycle at most; the write port accepts every cycle):
  - Only one requester valid: that requester is granted.
  - Both valid, LSU_PRIORITY = 1: LSU is granted.
  - Both valid, LSU_PRIORITY = 0: the requester not granted last is granted.
  - last_lsu updates only on a grant.
  - A ready output is high exactly in its grant cycle. Requesters must hold rd/data stable while valid and not ready.
- Write output, granted in cycle G:
  - At the end edge of G: rf_we <= (rd != 0), and rf_rd_addr/rf_rd_din load the granted rd/data.
  - During G+1: the write is presented to the register file, which captures it at the end edge of G+1.
  - No grant in G: rf_we <= 0 and rf_rd_addr/rf_rd_din hold their values.
  - rd = 0 requests are handshaken and consumed (they count as grants), but rf_we stays 0.
- Scoreboard:
  - Set: sb_set with sb_set_addr != 0 sets busy[sb_set_addr] at the next edge.
  - Clear: busy[rf_rd_addr] clears on the edge where rf_we = 1, i.e. the register file write edge. The bit is therefore visible through G+1 and cleared from G+2.
  - Same edge, same register, set and clear: set wins, and sb_err is not raised.
  - sb_set to an already busy register with no same-edge clear: sb_err <= 1, and the bit stays set.
  - rf_we = 1 to a register whose busy bit is 0: sb_err <= 1, and the write still happens.
  - sb_err is cleared only by reset.
- Stall counters: increment once per cycle of stall (valid high, ready low) and saturate at 2^CNT_W - 1 without wrapping.

Decomposition:
- defines.vh: REG_AW = 5, REG_NUM = 32, and WB_SRC_ALU = 0 / WB_SRC_LSU = 1 encodings for the grant/pointer.
- Sub-module wb_rr_arb2: 2-input arbiter holding the LSU_PRIORITY mux and the last_lsu pointer, producing one-hot grant.
- Scoreboard, write register and counters stay in the top module.

Test Plan:
- Single ALU write: alu_valid = 1, rd = 5, data = 0xDEADBEEF in cycle 0 with busy[5] preset:
  - alu_ready = 1 in cycle 0; rf_we = 1, addr = 5, din = 0xDEADBEEF in cycle 1; busy[5] = 0 from cycle 2; sb_err = 0.
- Round-robin contention: both valid for 4 cycles from reset, LSU_PRIORITY = 0:
  - Grants go LSU, ALU, LSU, ALU.
  - Each requester sees 2 stall cycles, so each counter = 2 (valid held).
- Fixed priority: LSU_PRIORITY = 1 with both valid for 3 cycles:
  - LSU is granted all 3 cycles and alu_stall_cnt = 3.
- x0 handling: alu_rd = 0 granted:
  - alu_ready = 1 and rf_we stays 0; sb_set_addr = 0 leaves busy_mask = 0; hz_rs1 = 0 for rs1_q = 0.
- Scoreboard races:
  - sb_set on reg 7 on the same edge a write to 7 commits: busy[7] = 1, sb_err = 0.
  - sb_set on reg 9 while busy[9] = 1: sb_err = 1, and it holds until reset.
- Async reset mid-operation: assert rst low mid-cycle while rf_we = 1 and busy_mask = 0x0000_00F0:
  - rf_we = 0 and busy_mask = 0 immediately, before the next clk edge.
  - After release, the first contended grant goes to the LSU.
